vm1_trap_arb: RTL and testbench

//  Trap/interrupt arbiter for the 1801VM1 soft CPU; sits between the instruction decoder and the

---
 rtl/vm1_trap_arb.sv | 212 +++++++++++++++++++++
 tb/tb_vm1_trap_arb.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vm1_trap_arb.sv
// Trap/interrupt arbiter for the 1801VM1 core: latches trap causes and hands the winning vector
// to the microsequencer over req/ack/done. Define VM1_TRAP_ARB_VIRQ_EN for device-supplied IRQ vectors.
module vm1_trap_arb #(
  parameter logic [7:0] IRQ_VEC  = 8'o100,
  parameter logic [7:0] BERR_VEC = 8'o004
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       berr,
  input  logic       op_stb,
  input  logic       op_unused,
  input  logic       op_bpt,
  input  logic       op_iot,
  input  logic       op_emt,
  input  logic       op_trap,
  input  logic       op_rtt,
  input  logic       psw_t,
  input  logic       psw_pri,
  input  logic       irq,
  input  logic [7:0] irq_vec,
  input  logic       insn_end,
  input  logic       trap_ack,
  input  logic       trap_done,
  output logic       trap_req,
  output logic [7:0] trap_vec,
  output logic       irq_iack,
  output logic       busy,
  output logic       dbl_err
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StSvc  = 2'd2;

  localparam logic [2:0] CauseBerr   = 3'd0;
  localparam logic [2:0] CauseUnused = 3'd1;
  localparam logic [2:0] CauseBpt    = 3'd2;
  localparam logic [2:0] CauseIot    = 3'd3;
  localparam logic [2:0] CauseEmt    = 3'd4;
  localparam logic [2:0] CauseTrap   = 3'd5;
  localparam logic [2:0] CauseTbit   = 3'd6;
  localparam logic [2:0] CauseIrq    = 3'd7;

  localparam logic [7:0] VecUnused = 8'o010;
  localparam logic [7:0] VecBpt    = 8'o014;
  localparam logic [7:0] VecIot    = 8'o020;
  localparam logic [7:0] VecEmt    = 8'o030;
  localparam logic [7:0] VecTrap   = 8'o034;
  localparam logic [7:0] VecTbit   = 8'o014;

  logic [1:0] state_q, state_d;
  logic       p_berr_q, p_berr_d;
  logic       p_unused_q, p_unused_d;
  logic [3:0] p_ins_q, p_ins_d;  // {bpt, iot, emt, trap}
  logic       t_armed_q, t_armed_d;
  logic       trap_req_q, trap_req_d;
  logic [7:0] trap_vec_q, trap_vec_d;
  logic [2:0] served_q, served_d;
  logic       dbl_err_q, dbl_err_d;

  logic       irq_ok;
  logic       any_cause;
  logic [2:0] sel_cause;
  logic [7:0] sel_vec;
  logic [7:0] irq_vec_sel;
  logic       ack_fire;

`ifdef VM1_TRAP_ARB_VIRQ_EN
  assign irq_vec_sel = irq_vec;
`else
  logic unused_irq_vec;
  assign unused_irq_vec = ^irq_vec;
  assign irq_vec_sel    = IRQ_VEC;
`endif

  // IRQ is a level, never latched: it only counts while present and unmasked.
  assign irq_ok    = irq & ~psw_pri;
  assign any_cause = p_berr_q | p_unused_q | (|p_ins_q) | t_armed_q | irq_ok;

  always_comb begin
    sel_cause = CauseIrq;
    sel_vec   = irq_vec_sel;
    if (p_berr_q) begin
      sel_cause = CauseBerr;
      sel_vec   = BERR_VEC;
    end else if (p_unused_q) begin
      sel_cause = CauseUnused;
      sel_vec   = VecUnused;
    end else if (p_ins_q[3]) begin
      sel_cause = CauseBpt;
      sel_vec   = VecBpt;
    end else if (p_ins_q[2]) begin
      sel_cause = CauseIot;
      sel_vec   = VecIot;
    end else if (p_ins_q[1]) begin
      sel_cause = CauseEmt;
      sel_vec   = VecEmt;
    end else if (p_ins_q[0]) begin
      sel_cause = CauseTrap;
      sel_vec   = VecTrap;
    end else if (t_armed_q) begin
      sel_cause = CauseTbit;
      sel_vec   = VecTbit;
    end
  end

  always_comb begin
    state_d    = state_q;
    trap_req_d = trap_req_q;
    trap_vec_d = trap_vec_q;
    served_d   = served_q;
    ack_fire   = 1'b0;
    case (state_q)
      StIdle: begin
        if (insn_end && any_cause) begin
          state_d    = StReq;
          trap_req_d = 1'b1;
          trap_vec_d = sel_vec;
          served_d   = sel_cause;
        end
      end
      StReq: begin
        // Request is frozen until acked, even if a higher-priority cause arrives meanwhile.
        if (trap_ack) begin
          ack_fire   = 1'b1;
          trap_req_d = 1'b0;
          state_d    = StSvc;
        end
      end
      StSvc: begin
        if (trap_done) begin
          if (any_cause) begin
            state_d    = StReq;
            trap_req_d = 1'b1;
            trap_vec_d = sel_vec;
            served_d   = sel_cause;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d    = StIdle;
        trap_req_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    p_berr_d   = p_berr_q;
    p_unused_d = p_unused_q;
    p_ins_d    = p_ins_q;
    t_armed_d  = t_armed_q;
    dbl_err_d  = dbl_err_q;
    if (ack_fire) begin
      case (served_q)
        CauseBerr:   p_berr_d   = 1'b0;
        CauseUnused: p_unused_d = 1'b0;
        CauseBpt:    p_ins_d[3] = 1'b0;
        CauseIot:    p_ins_d[2] = 1'b0;
        CauseEmt:    p_ins_d[1] = 1'b0;
        CauseTrap:   p_ins_d[0] = 1'b0;
        default:     ;
      endcase
      t_armed_d = 1'b0;
    end
    // A fresh decode strobe describes the newest instruction and overrides any ack clear.
    if (op_stb) begin
      p_unused_d = op_unused;
      p_ins_d    = {op_bpt, op_iot, op_emt, op_trap};
      t_armed_d  = psw_t & ~op_rtt;
    end
    if (berr) begin
      if (state_q == StSvc) begin
        dbl_err_d = 1'b1;
      end else begin
        p_berr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      p_berr_q   <= 1'b0;
      p_unused_q <= 1'b0;
      p_ins_q    <= 4'b0;
      t_armed_q  <= 1'b0;
      trap_req_q <= 1'b0;
      trap_vec_q <= 8'b0;
      served_q   <= CauseBerr;
      dbl_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_berr_q   <= p_berr_d;
      p_unused_q <= p_unused_d;
      p_ins_q    <= p_ins_d;
      t_armed_q  <= t_armed_d;
      trap_req_q <= trap_req_d;
      trap_vec_q <= trap_vec_d;
      served_q   <= served_d;
      dbl_err_q  <= dbl_err_d;
    end
  end

  assign trap_req = trap_req_q;
  assign trap_vec = trap_vec_q;
  assign irq_iack = ack_fire && (served_q == CauseIrq);
  assign busy     = (state_q != StIdle);
  assign dbl_err  = dbl_err_q;

endmodule

// File: tb/tb_vm1_trap_arb.sv
// Directed bench for vm1_trap_arb: a per-cycle vector table plus a hand-written reset sequence.
module tb_vm1_trap_arb;

`ifdef VM1_TRAP_ARB_VIRQ_EN
  localparam logic [7:0] ExpIrqVec = 8'o060;
`else
  localparam logic [7:0] ExpIrqVec = 8'o100;
`endif

  localparam logic [5:0] OpNone = 6'b000000;
  localparam logic [5:0] OpUnu  = 6'b100000;
  localparam logic [5:0] OpBpt  = 6'b010000;
  localparam logic [5:0] OpEmt  = 6'b000100;
  localparam logic [5:0] OpTrap = 6'b000010;
  localparam logic [5:0] OpRtt  = 6'b000001;

  logic clk = 1'b0;
  logic reset;
  logic berr, op_stb, op_unused, op_bpt, op_iot, op_emt, op_trap, op_rtt;
  logic psw_t, psw_pri, irq, insn_end, trap_ack, trap_done;
  logic [7:0] irq_vec;
  logic trap_req, irq_iack, busy, dbl_err;
  logic [7:0] trap_vec;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vm1_trap_arb dut (
    .clk       (clk),
    .reset     (reset),
    .berr      (berr),
    .op_stb    (op_stb),
    .op_unused (op_unused),
    .op_bpt    (op_bpt),
    .op_iot    (op_iot),
    .op_emt    (op_emt),
    .op_trap   (op_trap),
    .op_rtt    (op_rtt),
    .psw_t     (psw_t),
    .psw_pri   (psw_pri),
    .irq       (irq),
    .irq_vec   (irq_vec),
    .insn_end  (insn_end),
    .trap_ack  (trap_ack),
    .trap_done (trap_done),
    .trap_req  (trap_req),
    .trap_vec  (trap_vec),
    .irq_iack  (irq_iack),
    .busy      (busy),
    .dbl_err   (dbl_err)
  );

  typedef struct {
    logic       berr;
    logic       stb;
    logic [5:0] op;   // {unused, bpt, iot, emt, trap, rtt}
    logic       t;
    logic       pri;
    logic       irq;
    logic       ie;
    logic       ack;
    logic       done;
    logic       req;
    logic [7:0] vec;
    logic       iack;
    logic       busy;
    logic       dbl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic b, input logic s, input logic [5:0] o, input logic t,
                              input logic p, input logic q, input logic ie, input logic a,
                              input logic d, input logic req, input logic [7:0] v,
                              input logic ik, input logic bz, input logic db);
    vec_t r;
    r.berr = b; r.stb = s; r.op = o; r.t = t; r.pri = p; r.irq = q; r.ie = ie;
    r.ack = a; r.done = d; r.req = req; r.vec = v; r.iack = ik; r.busy = bz; r.dbl = db;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    berr = 0; op_stb = 0; op_unused = 0; op_bpt = 0; op_iot = 0; op_emt = 0; op_trap = 0;
    op_rtt = 0; psw_t = 0; psw_pri = 0; irq = 0; insn_end = 0; trap_ack = 0; trap_done = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: inputs for one cycle, outputs expected at the negedge of that same cycle.
    //               berr stb op    t  pri irq ie ack dn  req vec        iack busy dbl
    // EMT trap, full handshake
    tbl.push_back(mk(0, 1, OpEmt, 0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  1, 8'o030,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 1, 0,  1, 8'o030,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 1,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    // RTT suppresses T-bit; plain instruction with T set traps to 014
    tbl.push_back(mk(0, 1, OpRtt, 1, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 1, OpNone,1, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  1, 8'o014,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 1, 0,  1, 8'o014,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 1,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    // IRQ masked, then unmasked; berr arriving in REQ must not replace the IRQ vector
    tbl.push_back(mk(0, 0, OpNone,0, 1, 1, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 1, 1, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 1, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(1, 0, OpNone,0, 0, 1, 0, 0, 0,  1, ExpIrqVec, 0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 1, 0, 1, 0,  1, ExpIrqVec, 1, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 1, 0, 0, 0,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 1,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  1, 8'o004,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 1, 0,  1, 8'o004,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 1,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    // berr + unused opcode with T set in one cycle: 004, chained 010, no 014
    tbl.push_back(mk(1, 1, OpUnu, 1, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  1, 8'o004,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 1, 0,  1, 8'o004,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 1,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  1, 8'o010,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 1, 0,  1, 8'o010,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 1,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    // TRAP, then berr during service: sticky dbl_err, no berr request
    tbl.push_back(mk(0, 1, OpTrap,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 1, 0, 0,  0, 8'o000,    0, 0, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  1, 8'o034,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 1, 0,  1, 8'o034,    0, 1, 0));
    tbl.push_back(mk(1, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 1, 0));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 1, 1));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 1,  0, 8'o000,    0, 1, 1));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 1));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 1, 0, 0,  0, 8'o000,    0, 0, 1));
    tbl.push_back(mk(0, 0, OpNone,0, 0, 0, 0, 0, 0,  0, 8'o000,    0, 0, 1));

    irq_vec = 8'o060;
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    chk("rst_req", 0, {7'b0, trap_req}, 8'h00);
    chk("rst_vec", 0, trap_vec, 8'h00);
    chk("rst_iack", 0, {7'b0, irq_iack}, 8'h00);
    chk("rst_busy", 0, {7'b0, busy}, 8'h00);
    chk("rst_dbl", 0, {7'b0, dbl_err}, 8'h00);
    reset = 1'b0;
    step();

    foreach (tbl[i]) begin
      berr      = tbl[i].berr;
      op_stb    = tbl[i].stb;
      op_unused = tbl[i].op[5];
      op_bpt    = tbl[i].op[4];
      op_iot    = tbl[i].op[3];
      op_emt    = tbl[i].op[2];
      op_trap   = tbl[i].op[1];
      op_rtt    = tbl[i].op[0];
      psw_t     = tbl[i].t;
      psw_pri   = tbl[i].pri;
      irq       = tbl[i].irq;
      insn_end  = tbl[i].ie;
      trap_ack  = tbl[i].ack;
      trap_done = tbl[i].done;
      @(negedge clk);
      chk("req", i, {7'b0, trap_req}, {7'b0, tbl[i].req});
      chk("iack", i, {7'b0, irq_iack}, {7'b0, tbl[i].iack});
      chk("busy", i, {7'b0, busy}, {7'b0, tbl[i].busy});
      chk("dbl", i, {7'b0, dbl_err}, {7'b0, tbl[i].dbl});
      if (tbl[i].req) chk("vec", i, trap_vec, tbl[i].vec);
      step();
    end

    // Reset in the middle of a BPT request drops req/vec/dbl_err without a clock edge
    idle_inputs();
    op_stb = 1'b1;
    op_bpt = 1'b1;
    step();
    idle_inputs();
    insn_end = 1'b1;
    step();
    insn_end = 1'b0;
    begin
      int waited = 0;
      while (!trap_req && waited < 4) begin
        step();
        waited++;
      end
      chk("mid_req_seen", waited, {7'b0, trap_req}, 8'h01);
    end
    chk("mid_vec", 0, trap_vec, 8'o014);
    #2;
    reset = 1'b1;
    #1;
    chk("async_req", 0, {7'b0, trap_req}, 8'h00);
    chk("async_vec", 0, trap_vec, 8'h00);
    chk("async_busy", 0, {7'b0, busy}, 8'h00);
    chk("async_dbl", 0, {7'b0, dbl_err}, 8'h00);
    step();
    reset = 1'b0;
    insn_end = 1'b1;
    step();
    insn_end = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_req", k, {7'b0, trap_req}, 8'h00);
      chk("post_rst_busy", k, {7'b0, busy}, 8'h00);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
